wb_p_reg_slice: RTL and testbench
=================================

WB_P_REG_SLICE -- requirements
Module: wb_p_reg_slice

Interface
REQ-001 Parameter DATA_WIDTH, default 32: data bus width.
REQ-002 Parameter ADDR_WIDTH, default 32: address bus width.
REQ-003 Parameter GRANULARITY, default 8: select granularity; only 8, 16 or 32 are legal, and an illegal value SHALL cause $fatal at elaboration.
REQ-004 Parameter MAX_OUTSTANDING, default 4: maximum number of downstream requests awaiting ack; legal range 1..15.
REQ-005 clk_i  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-006 rst_i  input  1  reset, asynchronous, active-high.
REQ-007 s  wishbone_p_if.slave  -  upstream port; an upstream master drives it.
REQ-008 m  wishbone_p_if.master  -  downstream port; it drives a downstream slave.

Function
REQ-009 The block SHALL be a Wishbone B4 pipelined register slice with no combinational path from m to s or from s to m on any signal.
REQ-010 Upstream accept condition: s.cyc & s.stb & !s.stall.
REQ-011 Downstream issue condition: m.cyc & m.stb & !m.stall.
REQ-012 Each request is the tuple {adr, dat, we, sel} and SHALL be stored in a 2-entry skid buffer: one output register plus one skid register.
REQ-013 An accepted request SHALL appear on m no earlier than the next cycle, so the minimum forward latency is 1 cycle.
REQ-014 s.stall SHALL be a registered signal, asserted exactly when the skid register is occupied.
REQ-015 m.stb SHALL be asserted when the output register is valid and outstanding < MAX_OUTSTANDING.
REQ-016 m's address, data, we and sel SHALL be driven directly from the output register and SHALL stay stable while m.stb & m.stall.
REQ-017 When a request is issued and the skid register is valid in the same cycle, the skid contents SHALL move to the output register.
REQ-018 When a request is issued and accepted in the same cycle with the skid register empty, the new request SHALL go straight to the output register.
REQ-019 Request order SHALL be preserved; no request is dropped or duplicated while s.cyc stays high.
REQ-020 The outstanding counter SHALL be 4 bits: +1 on issue, -1 on m.ack, unchanged when both occur in the same cycle.
REQ-021 m.ack arriving while outstanding == 0 SHALL be ignored.
REQ-022 Ack path: s.ack SHALL equal m.ack registered by one cycle, and s.dat_o SHALL equal m.dat_i captured in the same cycle that m.ack is high.
REQ-023 s.dat_o SHALL hold its value when no ack is present.
REQ-024 m.cyc SHALL be registered: set on the cycle after s.cyc rises, held while s.cyc stays high.
REQ-025 Abort: when s.cyc is low, both buffer entries SHALL be invalidated, the outstanding counter cleared, m.cyc and m.stb deasserted on the next cycle, and a pending registered ack suppressed.
REQ-026 s.cyc low and s.stb high in the same cycle SHALL accept nothing.

Reset
REQ-027 On rst_i, asynchronously, outputs SHALL take these values: m.cyc=0, m.stb=0, m.we=0, m.adr=0, m.dat_o=0, m.sel=0, s.ack=0, s.stall=0, s.dat_o=0.
REQ-028 On rst_i, both buffer valid bits SHALL be 0 and the outstanding counter SHALL be 0.
REQ-029 Reset asserted mid-transfer SHALL discard all buffered and outstanding requests; the first request after deassertion SHALL be handled as in an empty-buffer state.

Structure
REQ-030 A shared package wb_pkg SHALL hold a parameterised request struct {adr, dat, we, sel} or equivalent width localparams, plus the legal-GRANULARITY check helper.
REQ-031 The skid buffer SHALL be one sub-module, wb_skid_buf (generic valid/ready, WIDTH parameter), reusable on the ack path of other blocks.
REQ-032 The outstanding counter and the cyc/abort control SHALL reside in wb_p_reg_slice.

Verification
REQ-033 Single write adr=0x10, dat=0xDEADBEEF, sel=0xF, m.stall=0 -> m.stb for 1 cycle at cycle+1 with identical fields; m.ack at cycle+2 -> s.ack at cycle+3.
REQ-034 m.stall held high while 3 back-to-back requests A, B, C are driven -> A held on m and B in skid, s.stall=1 from the cycle after B is accepted, C stalled; releasing m.stall -> A, B, C issue in order with none lost.
REQ-035 MAX_OUTSTANDING=2 with slave never acking -> exactly 2 issues, m.stb low thereafter; one m.ack -> a third issue follows.
REQ-036 Read with m.dat_i=0x12345678 on ack -> s.ack=1 and s.dat_o=0x12345678 on the next cycle, and s.dat_o holds afterwards.
REQ-037 s.cyc dropped with 1 buffered and 2 outstanding requests, then a late m.ack -> m.cyc=0 next cycle, no s.ack, counter=0.
REQ-038 rst_i pulsed asynchronously mid-burst, between clock edges -> all outputs take reset values immediately, and a fresh request after release has latency 1.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone helpers: default widths, select-width math and the
// legal-granularity check used at elaboration by the register slice.
package wb_pkg;

  localparam int unsigned WB_DEF_DATA_WIDTH  = 32;
  localparam int unsigned WB_DEF_ADDR_WIDTH  = 32;
  localparam int unsigned WB_DEF_GRANULARITY = 8;

  // Only byte, half-word and word select granularity are supported.
  function automatic bit wb_gran_legal(input int unsigned gran);
    return (gran == 8) || (gran == 16) || (gran == 32);
  endfunction

  // Number of select lines for a data bus; guarded so an illegal
  // granularity of 0 still elaborates far enough to reach the $fatal.
  function automatic int unsigned wb_sel_width(input int unsigned dw,
                                               input int unsigned gran);
    if (gran == 0) return 1;
    return (dw + gran - 1) / gran;
  endfunction

  // Packed width of one request tuple {adr, dat, we, sel}.
  function automatic int unsigned wb_req_width(input int unsigned aw,
                                               input int unsigned dw,
                                               input int unsigned sw);
    return aw + dw + 1 + sw;
  endfunction

endpackage

// File: rtl/wishbone_p_if.sv
// Wishbone B4 pipelined bus. Signal names follow the master's view:
// dat_o carries write data toward the slave, dat_i carries read data back,
// so the slave modport drives the read data on dat_i.
interface wishbone_p_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned SEL_WIDTH  = 4
);
  logic                  cyc;
  logic                  stb;
  logic                  we;
  logic [ADDR_WIDTH-1:0] adr;
  logic [DATA_WIDTH-1:0] dat_o;
  logic [DATA_WIDTH-1:0] dat_i;
  logic [SEL_WIDTH-1:0]  sel;
  logic                  stall;
  logic                  ack;

  modport master (output cyc, stb, we, adr, dat_o, sel,
                  input  dat_i, stall, ack);
  modport slave  (input  cyc, stb, we, adr, dat_o, sel,
                  output dat_i, stall, ack);
endinterface

// File: rtl/wb_skid_buf.sv
// Two-entry skid buffer (output register + skid register) with generic
// valid/ready handshakes. o_ready is a registered signal: it is low exactly
// when the skid register holds data, so no ready path crosses the buffer.
module wb_skid_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready
);

  logic             r_out_valid;
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [WIDTH-1:0] r_skid_data;

  logic w_push;
  logic w_pop;
  logic w_out_free;

  assign w_push     = i_valid & ~r_skid_valid;
  assign w_pop      = r_out_valid & i_ready;
  assign w_out_free = ~r_out_valid | w_pop;

  assign o_ready = ~r_skid_valid;
  assign o_valid = r_out_valid;
  assign o_data  = r_out_data;

  // Occupancy: the output slot refills from skid first, else from the input;
  // the skid only fills when the output slot is busy and not draining.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (i_flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_out_free) begin
      r_out_valid  <= r_skid_valid | w_push;
      r_skid_valid <= 1'b0;
    end else if (w_push) begin
      r_skid_valid <= 1'b1;
    end
  end

  // Payload movement mirrors the occupancy rules; output data is held
  // unchanged whenever the output slot is occupied and not draining.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_data  <= '0;
      r_skid_data <= '0;
    end else begin
      if (w_out_free) begin
        if (r_skid_valid)  r_out_data <= r_skid_data;
        else if (w_push)   r_out_data <= i_data;
      end else if (w_push) begin
        r_skid_data <= i_data;
      end
    end
  end

endmodule

// File: rtl/wb_p_reg_slice.sv
// Wishbone B4 pipelined register slice: requests pass through a 2-entry
// skid buffer, acks and read data are registered, and every output on
// either port comes from a flop (no port-to-port combinational path).
module wb_p_reg_slice
  import wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = WB_DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH      = WB_DEF_ADDR_WIDTH,
  parameter int unsigned GRANULARITY     = WB_DEF_GRANULARITY,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  wishbone_p_if.slave   s,
  wishbone_p_if.master  m
);

  localparam int unsigned SEL_WIDTH = wb_sel_width(DATA_WIDTH, GRANULARITY);
  localparam int unsigned REQ_WIDTH = wb_req_width(ADDR_WIDTH, DATA_WIDTH, SEL_WIDTH);
  localparam logic [3:0]  MAX_OUT   = 4'(MAX_OUTSTANDING);

  if (!wb_gran_legal(GRANULARITY)) begin : g_bad_granularity
    $fatal(1, "wb_p_reg_slice: GRANULARITY must be 8, 16 or 32");
  end

  if ((MAX_OUTSTANDING < 1) || (MAX_OUTSTANDING > 15)) begin : g_bad_max_outstanding
    $fatal(1, "wb_p_reg_slice: MAX_OUTSTANDING must be in 1..15");
  end

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] adr;
    logic [DATA_WIDTH-1:0] dat;
    logic                  we;
    logic [SEL_WIDTH-1:0]  sel;
  } req_t;

  req_t                  w_s_req;
  req_t                  w_m_req;
  logic                  w_flush;
  logic                  w_s_valid;
  logic                  w_s_ready;
  logic                  w_m_valid;
  logic                  w_m_ready;
  logic                  w_below_max;
  logic                  w_stb;
  logic                  w_issue;
  logic                  w_ack_ok;

  logic                  r_cyc;
  logic                  r_ack;
  logic [DATA_WIDTH-1:0] r_rdat;
  logic [3:0]            r_outst;

  assign w_s_req.adr = s.adr;
  assign w_s_req.dat = s.dat_o;
  assign w_s_req.we  = s.we;
  assign w_s_req.sel = s.sel;

  // Dropping s.cyc aborts the whole transfer; a strobe without cyc is ignored.
  assign w_flush     = ~s.cyc;
  assign w_s_valid   = s.cyc & s.stb;
  assign w_below_max = (r_outst < MAX_OUT);
  assign w_stb       = r_cyc & w_m_valid & w_below_max;
  assign w_m_ready   = r_cyc & w_below_max & ~m.stall;
  assign w_issue     = w_stb & ~m.stall;
  assign w_ack_ok    = m.ack & s.cyc & (r_outst != 4'd0);

  wb_skid_buf #(
    .WIDTH (REQ_WIDTH)
  ) u_req_buf (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_flush (w_flush),
    .i_valid (w_s_valid),
    .i_data  (w_s_req),
    .o_ready (w_s_ready),
    .o_valid (w_m_valid),
    .o_data  (w_m_req),
    .i_ready (w_m_ready)
  );

  assign m.cyc   = r_cyc;
  assign m.stb   = w_stb;
  assign m.adr   = w_m_req.adr;
  assign m.dat_o = w_m_req.dat;
  assign m.we    = w_m_req.we;
  assign m.sel   = w_m_req.sel;

  assign s.stall = ~w_s_ready;
  assign s.ack   = r_ack;
  assign s.dat_i = r_rdat;

  // Downstream cycle follows upstream cycle one clock later.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_cyc <= 1'b0;
    else       r_cyc <= s.cyc;
  end

  // Outstanding requests: issue and ack in the same cycle cancel out.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                       r_outst <= '0;
    else if (w_flush)                r_outst <= '0;
    else if (w_issue && !w_ack_ok)   r_outst <= r_outst + 4'd1;
    else if (!w_issue && w_ack_ok)   r_outst <= r_outst - 4'd1;
  end

  // Ack path: registered ack and read data; data holds between acks.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ack  <= 1'b0;
      r_rdat <= '0;
    end else begin
      r_ack <= w_ack_ok;
      if (w_ack_ok) r_rdat <= m.dat_i;
    end
  end

endmodule

// File: tb/tb_wb_p_reg_slice.sv
module tb_wb_p_reg_slice;

  localparam int MAXO = 2;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    logic [3:0]  sel;
  } req_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  wishbone_p_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SEL_WIDTH(4)) s_bus ();
  wishbone_p_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SEL_WIDTH(4)) m_bus ();

  wb_p_reg_slice #(
    .DATA_WIDTH      (32),
    .ADDR_WIDTH      (32),
    .GRANULARITY     (8),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .s     (s_bus),
    .m     (m_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s_bus.cyc = 0; s_bus.stb = 0; s_bus.we = 0;
    s_bus.adr = '0; s_bus.dat_o = '0; s_bus.sel = '0;
    m_bus.stall = 0; m_bus.ack = 0; m_bus.dat_i = '0;
  endtask

  task automatic test_reset();
    logic [63:0] got [9];
    string       nm  [9];
    #2;
    got = '{64'(m_bus.cyc), 64'(m_bus.stb), 64'(m_bus.we), 64'(m_bus.adr),
            64'(m_bus.dat_o), 64'(m_bus.sel), 64'(s_bus.ack), 64'(s_bus.stall),
            64'(s_bus.dat_i)};
    nm  = '{"m_cyc", "m_stb", "m_we", "m_adr", "m_dat_o", "m_sel", "s_ack", "s_stall", "s_dat_o"};
    for (int i = 0; i < 9; i++) begin
      n_cmp++;
      if (got[i] !== 64'd0) begin
        n_err++;
        $display("FAIL reset_%s got=%h exp=0", nm[i], got[i]);
      end
    end
    tick();
    rst = 0;
    tick();
  endtask

  task automatic test_single_write();
    s_bus.cyc = 1; s_bus.stb = 1; s_bus.we = 1;
    s_bus.adr = 32'h10; s_bus.dat_o = 32'hDEADBEEF; s_bus.sel = 4'hF;
    #1;
    n_cmp++;
    if (m_bus.stb !== 1'b0) begin
      n_err++; $display("FAIL sw_no_same_cycle got stb=%b exp=0", m_bus.stb);
    end
    tick();
    s_bus.stb = 0;
    n_cmp++;
    if (!(m_bus.stb === 1'b1 && m_bus.cyc === 1'b1 && m_bus.adr === 32'h10 &&
          m_bus.dat_o === 32'hDEADBEEF && m_bus.we === 1'b1 && m_bus.sel === 4'hF)) begin
      n_err++;
      $display("FAIL sw_fields got stb=%b cyc=%b adr=%h dat=%h we=%b sel=%h exp 1 1 00000010 deadbeef 1 f",
               m_bus.stb, m_bus.cyc, m_bus.adr, m_bus.dat_o, m_bus.we, m_bus.sel);
    end
    tick();
    n_cmp++;
    if (m_bus.stb !== 1'b0) begin
      n_err++; $display("FAIL sw_one_strobe got stb=%b exp=0", m_bus.stb);
    end
    m_bus.ack = 1;
    n_cmp++;
    if (s_bus.ack !== 1'b0) begin
      n_err++; $display("FAIL sw_ack_early got=%b exp=0", s_bus.ack);
    end
    tick();
    m_bus.ack = 0;
    n_cmp++;
    if (s_bus.ack !== 1'b1) begin
      n_err++; $display("FAIL sw_ack got=%b exp=1", s_bus.ack);
    end
    tick();
    n_cmp++;
    if (s_bus.ack !== 1'b0) begin
      n_err++; $display("FAIL sw_ack_once got=%b exp=0", s_bus.ack);
    end
    idle();
    tick(); tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_adr [3];
    logic [31:0] order [$];
    bit iss, acc, pend, drop;
    exp_adr = '{32'h100, 32'h104, 32'h108};
    m_bus.stall = 1;
    s_bus.cyc = 1; s_bus.stb = 1; s_bus.we = 1; s_bus.sel = 4'hF;
    s_bus.adr = exp_adr[0]; s_bus.dat_o = exp_adr[0] ^ 32'h5555;
    tick();
    n_cmp++;
    if (s_bus.stall !== 1'b0 || m_bus.stb !== 1'b1 || m_bus.adr !== exp_adr[0]) begin
      n_err++; $display("FAIL bp_a_out got stall=%b stb=%b adr=%h exp 0 1 %h",
                        s_bus.stall, m_bus.stb, m_bus.adr, exp_adr[0]);
    end
    s_bus.adr = exp_adr[1]; s_bus.dat_o = exp_adr[1] ^ 32'h5555;
    tick();
    n_cmp++;
    if (s_bus.stall !== 1'b1 || m_bus.adr !== exp_adr[0]) begin
      n_err++; $display("FAIL bp_b_skid got stall=%b adr=%h exp 1 %h",
                        s_bus.stall, m_bus.adr, exp_adr[0]);
    end
    s_bus.adr = exp_adr[2]; s_bus.dat_o = exp_adr[2] ^ 32'h5555;
    tick();
    tick();
    n_cmp++;
    if (s_bus.stall !== 1'b1 || m_bus.stb !== 1'b1 || m_bus.adr !== exp_adr[0] ||
        m_bus.dat_o !== (exp_adr[0] ^ 32'h5555)) begin
      n_err++; $display("FAIL bp_hold got stall=%b stb=%b adr=%h dat=%h exp 1 1 %h %h",
                        s_bus.stall, m_bus.stb, m_bus.adr, m_bus.dat_o, exp_adr[0],
                        exp_adr[0] ^ 32'h5555);
    end
    m_bus.stall = 0;
    pend = 0; drop = 0;
    for (int k = 0; k < 12; k++) begin
      m_bus.ack = pend;
      m_bus.dat_i = $urandom;
      if (drop) s_bus.stb = 0;
      iss = m_bus.cyc && m_bus.stb && !m_bus.stall;
      acc = s_bus.cyc && s_bus.stb && !s_bus.stall;
      if (iss) order.push_back(m_bus.adr);
      pend = iss;
      drop = drop || acc;
      tick();
    end
    n_cmp++;
    if (order.size() != 3) begin
      n_err++; $display("FAIL bp_count got=%0d exp=3", order.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (order[i] !== exp_adr[i]) begin
          n_err++; $display("FAIL bp_order[%0d] got=%h exp=%h", i, order[i], exp_adr[i]);
        end
      end
    end
    idle();
    tick(); tick();
  endtask

  task automatic test_max_outstanding();
    int idx, n_iss;
    logic [31:0] last_adr;
    bit iss, acc;
    idx = 0; n_iss = 0; last_adr = '0;
    s_bus.cyc = 1; s_bus.we = 1; s_bus.sel = 4'h3;
    for (int k = 0; k < 12; k++) begin
      if (idx < 4) begin
        s_bus.stb = 1; s_bus.adr = 32'h200 + 32'(idx * 4); s_bus.dat_o = $urandom;
      end else begin
        s_bus.stb = 0;
      end
      iss = m_bus.cyc && m_bus.stb && !m_bus.stall;
      acc = s_bus.cyc && s_bus.stb && !s_bus.stall;
      if (acc) idx++;
      if (iss) n_iss++;
      tick();
    end
    n_cmp++;
    if (n_iss != MAXO) begin
      n_err++; $display("FAIL mo_issues got=%0d exp=%0d", n_iss, MAXO);
    end
    n_cmp++;
    if (m_bus.stb !== 1'b0 || s_bus.stall !== 1'b1) begin
      n_err++; $display("FAIL mo_blocked got stb=%b stall=%b exp 0 1", m_bus.stb, s_bus.stall);
    end
    m_bus.ack = 1;
    tick();
    m_bus.ack = 0;
    n_iss = 0;
    for (int k = 0; k < 6; k++) begin
      iss = m_bus.cyc && m_bus.stb && !m_bus.stall;
      if (iss) begin n_iss++; last_adr = m_bus.adr; end
      tick();
    end
    n_cmp++;
    if (n_iss != 1 || last_adr !== 32'h208) begin
      n_err++; $display("FAIL mo_after_ack got issues=%0d adr=%h exp 1 00000208", n_iss, last_adr);
    end
    idle();
    tick(); tick();
  endtask

  task automatic test_read();
    s_bus.cyc = 1; s_bus.stb = 1; s_bus.we = 0; s_bus.adr = 32'h20; s_bus.sel = 4'hF;
    tick();
    s_bus.stb = 0;
    n_cmp++;
    if (m_bus.stb !== 1'b1 || m_bus.we !== 1'b0) begin
      n_err++; $display("FAIL rd_issue got stb=%b we=%b exp 1 0", m_bus.stb, m_bus.we);
    end
    tick();
    m_bus.ack = 1; m_bus.dat_i = 32'h12345678;
    tick();
    m_bus.ack = 0; m_bus.dat_i = 32'hA5A5A5A5;
    n_cmp++;
    if (s_bus.ack !== 1'b1 || s_bus.dat_i !== 32'h12345678) begin
      n_err++; $display("FAIL rd_data got ack=%b dat=%h exp 1 12345678", s_bus.ack, s_bus.dat_i);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++;
      if (s_bus.ack !== 1'b0 || s_bus.dat_i !== 32'h12345678) begin
        n_err++; $display("FAIL rd_hold[%0d] got ack=%b dat=%h exp 0 12345678", k, s_bus.ack, s_bus.dat_i);
      end
    end
    idle();
    tick(); tick();
  endtask

  task automatic test_abort();
    int idx, n_iss;
    logic [31:0] order [$];
    bit iss, acc;
    idx = 0; n_iss = 0;
    s_bus.cyc = 1; s_bus.we = 1; s_bus.sel = 4'hF;
    for (int k = 0; k < 8; k++) begin
      if (idx < 3) begin s_bus.stb = 1; s_bus.adr = 32'h300 + 32'(idx * 4); end
      else s_bus.stb = 0;
      iss = m_bus.cyc && m_bus.stb && !m_bus.stall;
      acc = s_bus.cyc && s_bus.stb && !s_bus.stall;
      if (acc) idx++;
      if (iss) n_iss++;
      tick();
    end
    n_cmp++;
    if (n_iss != 2 || m_bus.stb !== 1'b0 || s_bus.stall !== 1'b0) begin
      n_err++; $display("FAIL ab_setup got issues=%0d stb=%b stall=%b exp 2 0 0", n_iss, m_bus.stb, s_bus.stall);
    end
    s_bus.cyc = 0; s_bus.stb = 1; s_bus.adr = 32'h3F0;
    tick();
    n_cmp++;
    if (m_bus.cyc !== 1'b0 || m_bus.stb !== 1'b0) begin
      n_err++; $display("FAIL ab_mcyc got cyc=%b stb=%b exp 0 0", m_bus.cyc, m_bus.stb);
    end
    m_bus.ack = 1; m_bus.dat_i = 32'hBAD0BAD0;
    tick();
    m_bus.ack = 0;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (s_bus.ack !== 1'b0) begin
        n_err++; $display("FAIL ab_no_ack[%0d] got=%b exp=0", k, s_bus.ack);
      end
      tick();
    end
    idx = 0;
    s_bus.cyc = 1;
    for (int k = 0; k < 10; k++) begin
      if (idx < 2) begin s_bus.stb = 1; s_bus.adr = 32'h3A0 + 32'(idx * 4); end
      else s_bus.stb = 0;
      iss = m_bus.cyc && m_bus.stb && !m_bus.stall;
      acc = s_bus.cyc && s_bus.stb && !s_bus.stall;
      if (acc) idx++;
      if (iss) order.push_back(m_bus.adr);
      tick();
    end
    n_cmp++;
    if (order.size() != 2) begin
      n_err++; $display("FAIL ab_restart_count got=%0d exp=2", order.size());
    end else begin
      n_cmp++;
      if (order[0] !== 32'h3A0 || order[1] !== 32'h3A4) begin
        n_err++; $display("FAIL ab_restart_order got=%h,%h exp=000003a0,000003a4", order[0], order[1]);
      end
    end
    idle();
    tick(); tick();
  endtask

  task automatic test_async_reset();
    logic [63:0] got [9];
    string       nm  [9];
    m_bus.stall = 1;
    s_bus.cyc = 1; s_bus.stb = 1; s_bus.we = 1; s_bus.sel = 4'hF;
    s_bus.adr = 32'h400; s_bus.dat_o = 32'h11111111;
    tick();
    s_bus.adr = 32'h404; s_bus.dat_o = 32'h22222222;
    tick();
    s_bus.stb = 0;
    n_cmp++;
    if (s_bus.stall !== 1'b1 || m_bus.stb !== 1'b1) begin
      n_err++; $display("FAIL ar_setup got stall=%b stb=%b exp 1 1", s_bus.stall, m_bus.stb);
    end
    #3;
    rst = 1;
    #1;
    got = '{64'(m_bus.cyc), 64'(m_bus.stb), 64'(m_bus.we), 64'(m_bus.adr),
            64'(m_bus.dat_o), 64'(m_bus.sel), 64'(s_bus.ack), 64'(s_bus.stall),
            64'(s_bus.dat_i)};
    nm  = '{"m_cyc", "m_stb", "m_we", "m_adr", "m_dat_o", "m_sel", "s_ack", "s_stall", "s_dat_o"};
    for (int i = 0; i < 9; i++) begin
      n_cmp++;
      if (got[i] !== 64'd0) begin
        n_err++; $display("FAIL ar_%s got=%h exp=0", nm[i], got[i]);
      end
    end
    #1;
    rst = 0;
    m_bus.stall = 0;
    s_bus.stb = 1; s_bus.adr = 32'h4C0; s_bus.dat_o = 32'hCAFEF00D;
    tick();
    s_bus.stb = 0;
    n_cmp++;
    if (m_bus.stb !== 1'b1 || m_bus.cyc !== 1'b1 || m_bus.adr !== 32'h4C0 ||
        m_bus.dat_o !== 32'hCAFEF00D || s_bus.stall !== 1'b0) begin
      n_err++; $display("FAIL ar_fresh got stb=%b cyc=%b adr=%h dat=%h stall=%b exp 1 1 000004c0 cafef00d 0",
                        m_bus.stb, m_bus.cyc, m_bus.adr, m_bus.dat_o, s_bus.stall);
    end
    tick();
    n_cmp++;
    if (m_bus.stb !== 1'b0) begin
      n_err++; $display("FAIL ar_no_stale got stb=%b adr=%h exp 0", m_bus.stb, m_bus.adr);
    end
    idle();
    tick(); tick();
  endtask

  task automatic test_random();
    req_t        q [$];
    req_t        nreq;
    int          outst;
    bit          exp_mcyc, exp_ack, exp_stb, iss, ack_ok, acc;
    logic [31:0] exp_dat;
    rst = 1;
    tick();
    rst = 0;
    tick();
    outst = 0; exp_mcyc = 0; exp_ack = 0; exp_dat = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      exp_stb = (q.size() > 0) && (outst < MAXO);
      n_cmp++;
      if (m_bus.cyc !== exp_mcyc) begin
        n_err++; $display("FAIL rnd_m_cyc @%0d got=%b exp=%b", cyc, m_bus.cyc, exp_mcyc);
      end
      n_cmp++;
      if (m_bus.stb !== exp_stb) begin
        n_err++; $display("FAIL rnd_m_stb @%0d got=%b exp=%b", cyc, m_bus.stb, exp_stb);
      end
      n_cmp++;
      if (s_bus.stall !== (q.size() == 2)) begin
        n_err++; $display("FAIL rnd_s_stall @%0d got=%b exp=%b", cyc, s_bus.stall, q.size() == 2);
      end
      n_cmp++;
      if (s_bus.ack !== exp_ack) begin
        n_err++; $display("FAIL rnd_s_ack @%0d got=%b exp=%b", cyc, s_bus.ack, exp_ack);
      end
      n_cmp++;
      if (s_bus.dat_i !== exp_dat) begin
        n_err++; $display("FAIL rnd_s_dat @%0d got=%h exp=%h", cyc, s_bus.dat_i, exp_dat);
      end
      if (exp_stb) begin
        n_cmp++;
        if ({m_bus.adr, m_bus.dat_o, m_bus.we, m_bus.sel} !== q[0]) begin
          n_err++; $display("FAIL rnd_m_req @%0d got=%h/%h/%b/%h exp=%h/%h/%b/%h", cyc,
                            m_bus.adr, m_bus.dat_o, m_bus.we, m_bus.sel,
                            q[0].adr, q[0].dat, q[0].we, q[0].sel);
        end
      end

      nreq.adr = $urandom; nreq.dat = $urandom;
      nreq.we  = 1'($urandom_range(0, 1)); nreq.sel = 4'($urandom_range(0, 15));
      s_bus.cyc   = ($urandom_range(0, 99) >= 4);
      s_bus.stb   = ($urandom_range(0, 99) < 60);
      s_bus.adr   = nreq.adr; s_bus.dat_o = nreq.dat;
      s_bus.we    = nreq.we;  s_bus.sel   = nreq.sel;
      m_bus.stall = ($urandom_range(0, 99) < 30);
      m_bus.ack   = ($urandom_range(0, 99) < 40);
      m_bus.dat_i = $urandom;

      if (!s_bus.cyc) begin
        q.delete();
        outst = 0; exp_ack = 0; exp_mcyc = 0;
      end else begin
        iss    = exp_stb && !m_bus.stall;
        ack_ok = m_bus.ack && (outst > 0);
        acc    = s_bus.stb && (q.size() < 2);
        if (iss) void'(q.pop_front());
        if (acc) q.push_back(nreq);
        outst  = outst + int'(iss) - int'(ack_ok);
        exp_ack = ack_ok;
        if (ack_ok) exp_dat = m_bus.dat_i;
        exp_mcyc = 1;
      end
      tick();
    end
    idle();
    tick(); tick();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1;
    idle();
    test_reset();
    test_single_write();
    test_backpressure();
    test_max_outstanding();
    test_read();
    test_abort();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
